// File: rtl/ddc_scan_controller.sv
// Scans the DDC mixer across a phase-increment table and averages dB outputs per channel.
// Optional macro SCAN_PEAK_HOLD_EN adds peak_o, the per-channel maximum dB sample.
module ddc_scan_controller #(
    parameter int NUM_CH         = 4,
    parameter int PINC_W         = 24,
    parameter int SETTLE_SAMPLES = 16,
    parameter int AVG_LOG2       = 3,
    localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic              abort_i,
    input  logic              cfg_wr_en_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [PINC_W-1:0] cfg_data_i,
    input  logic [15:0]       dp_db_i,
    input  logic              dp_valid_i,
    output logic              dp_en_o,
    output logic              dp_flush_o,
    output logic [PINC_W-1:0] dp_pinc_o,
    output logic [15:0]       result_o,
    output logic [3:0]        result_ch_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              busy_o
`ifdef SCAN_PEAK_HOLD_EN
    ,
    output logic [15:0]       peak_o
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_ACCUM  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    localparam int DEPTH = 1 << AW;
    localparam int SW    = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = 16 + AVG_LOG2;

    localparam logic [SW-1:0] SET_LAST =
        SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CW-1:0] AVG_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]    LAST_CH  = 4'(NUM_CH - 1);
    localparam logic [AW:0]   CH_LIMIT = (AW + 1)'(NUM_CH);

    logic [PINC_W-1:0] tbl [DEPTH];
    logic [2:0]        state;
    logic [3:0]        ch;
    logic [SW-1:0]     set_cnt;
    logic [CW-1:0]     avg_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic              handshake;

    assign acc_sum    = acc + ACC_W'(dp_db_i);
    assign handshake  = result_valid_o && result_ready_i;
    assign dp_en_o    = (state == S_SETTLE) || (state == S_ACCUM);
    assign dp_flush_o = (state == S_LOAD);
    assign busy_o     = (state != S_IDLE);

    // Table is only sampled in LOAD, so live edits apply on the next visit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_wr_en_i && ({1'b0, cfg_addr_i} < CH_LIMIT)) begin
            tbl[cfg_addr_i] <= cfg_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            ch             <= '0;
            set_cnt        <= '0;
            avg_cnt        <= '0;
            acc            <= '0;
            dp_pinc_o      <= '0;
            result_o       <= '0;
            result_ch_o    <= '0;
            result_valid_o <= 1'b0;
        end else if (abort_i) begin
            state          <= S_IDLE;
            result_valid_o <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ch    <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dp_pinc_o <= tbl[ch[AW-1:0]];
                    set_cnt   <= '0;
                    avg_cnt   <= '0;
                    acc       <= '0;
                    state     <= (SETTLE_SAMPLES == 0) ? S_ACCUM : S_SETTLE;
                end
                S_SETTLE: begin
                    if (dp_valid_i) begin
                        if (set_cnt == SET_LAST) begin
                            state <= S_ACCUM;
                        end else begin
                            set_cnt <= set_cnt + 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (dp_valid_i) begin
                        acc     <= acc_sum;
                        avg_cnt <= avg_cnt + 1'b1;
                        if (avg_cnt == AVG_LAST) begin
                            result_o       <= acc_sum[AVG_LOG2 +: 16];
                            result_ch_o    <= ch;
                            result_valid_o <= 1'b1;
                            state          <= S_OUTPUT;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (handshake) begin
                        result_valid_o <= 1'b0;
                        if (ch == LAST_CH && !continuous_i) begin
                            state <= S_IDLE;
                        end else begin
                            ch    <= (ch == LAST_CH) ? 4'd0 : ch + 4'd1;
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCAN_PEAK_HOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_o <= '0;
        end else if (!abort_i) begin
            if (state == S_LOAD) begin
                peak_o <= '0;
            end else if (state == S_ACCUM && dp_valid_i && dp_db_i > peak_o) begin
                peak_o <= dp_db_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddc_scan_controller.sv
// Randomised bench for ddc_scan_controller with a per-channel window model.
// A second small instance covers zero settle, single-sample average and bad addresses.
module tb_ddc_scan_controller;

    localparam int NUM_CH = 4;
    localparam int PINC_W = 24;
    localparam int SETTLE = 16;
    localparam int AVG_LOG2 = 3;
    localparam int NAVG = 1 << AVG_LOG2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              continuous_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              cfg_wr_en_i = 1'b0;
    logic [1:0]        cfg_addr_i = '0;
    logic [PINC_W-1:0] cfg_data_i = '0;
    logic [15:0]       dp_db_i = '0;
    logic              dp_valid_i = 1'b0;
    logic              result_ready_i = 1'b1;
    logic              dp_en_o, dp_flush_o, result_valid_o, busy_o;
    logic [PINC_W-1:0] dp_pinc_o;
    logic [15:0]       result_o;
    logic [3:0]        result_ch_o;
`ifdef SCAN_PEAK_HOLD_EN
    logic [15:0]       peak_o;
    logic [15:0]       s_peak;
`endif

    ddc_scan_controller #(
        .NUM_CH(NUM_CH), .PINC_W(PINC_W),
        .SETTLE_SAMPLES(SETTLE), .AVG_LOG2(AVG_LOG2)
    ) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .continuous_i(continuous_i), .abort_i(abort_i),
        .cfg_wr_en_i(cfg_wr_en_i), .cfg_addr_i(cfg_addr_i),
        .cfg_data_i(cfg_data_i), .dp_db_i(dp_db_i),
        .dp_valid_i(dp_valid_i), .dp_en_o(dp_en_o),
        .dp_flush_o(dp_flush_o), .dp_pinc_o(dp_pinc_o),
        .result_o(result_o), .result_ch_o(result_ch_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i), .busy_o(busy_o)
`ifdef SCAN_PEAK_HOLD_EN
        , .peak_o(peak_o)
`endif
    );

    logic              s_start = 1'b0;
    logic              s_wr = 1'b0;
    logic [1:0]        s_addr = '0;
    logic [PINC_W-1:0] s_data = '0;
    logic [15:0]       s_db = '0;
    logic              s_valid = 1'b0;
    logic              s_en, s_flush, s_rvalid, s_busy;
    logic [PINC_W-1:0] s_pinc;
    logic [15:0]       s_result;
    logic [3:0]        s_rch;

    ddc_scan_controller #(
        .NUM_CH(3), .PINC_W(PINC_W), .SETTLE_SAMPLES(0), .AVG_LOG2(0)
    ) u_small (
        .clk(clk), .rst(rst), .start_i(s_start),
        .continuous_i(1'b0), .abort_i(1'b0),
        .cfg_wr_en_i(s_wr), .cfg_addr_i(s_addr),
        .cfg_data_i(s_data), .dp_db_i(s_db),
        .dp_valid_i(s_valid), .dp_en_o(s_en),
        .dp_flush_o(s_flush), .dp_pinc_o(s_pinc),
        .result_o(s_result), .result_ch_o(s_rch),
        .result_valid_o(s_rvalid),
        .result_ready_i(1'b1), .busy_o(s_busy)
`ifdef SCAN_PEAK_HOLD_EN
        , .peak_o(s_peak)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int                ch;
        logic [PINC_W-1:0] pinc;
        logic [15:0]       avg;
        logic [15:0]       peak;
    } rec_t;

    rec_t              exp_q[$];
    logic [PINC_W-1:0] m_tbl [NUM_CH];
    bit                mon_flush = 0, mon_busy = 0;
    int                flush_cnt = 0;
    bit                win_open = 0;
    int                win_cnt = 0, win_ch = 0, flush_idx = 0, win_pk = 0;
    longint            win_sum = 0;
    logic [PINC_W-1:0] win_pinc = '0;

    // Outputs observed mid-cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        mon_flush = dp_flush_o;
        mon_busy  = busy_o;
        if (dp_flush_o) flush_cnt++;
    end

    // Reference: after each flush, skip SETTLE valid samples, average the next NAVG.
    initial begin
        foreach (m_tbl[i]) m_tbl[i] = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                foreach (m_tbl[i]) m_tbl[i] = '0;
                win_open  = 0;
                flush_idx = 0;
            end else if (abort_i) begin
                win_open = 0;
            end else begin
                if (start_i && !mon_busy) flush_idx = 0;
                if (mon_flush) begin
                    win_open = 1;
                    win_cnt  = 0;
                    win_sum  = 0;
                    win_pk   = 0;
                    win_ch   = flush_idx % NUM_CH;
                    win_pinc = m_tbl[win_ch];
                    flush_idx++;
                end else if (win_open && dp_valid_i) begin
                    if (win_cnt >= SETTLE) begin
                        win_sum += dp_db_i;
                        if (int'(dp_db_i) > win_pk) win_pk = dp_db_i;
                    end
                    win_cnt++;
                    if (win_cnt == SETTLE + NAVG) begin
                        exp_q.push_back('{win_ch, win_pinc,
                            16'(win_sum / NAVG), 16'(win_pk)});
                        win_open = 0;
                    end
                end
            end
            if (rst && cfg_wr_en_i && int'(cfg_addr_i) < NUM_CH)
                m_tbl[cfg_addr_i] = cfg_data_i;
        end
    end

    bit          rand_en = 0;
    bit          feed_go = 0;
    logic [15:0] feed_q[$];

    initial forever begin
        @(posedge clk);
        #1;
        if (mon_flush) feed_go = 1;
        if (feed_go && feed_q.size() > 0) begin
            dp_valid_i = 1'b1;
            dp_db_i    = feed_q.pop_front();
        end else begin
            feed_go    = 0;
            dp_valid_i = rand_en && ($urandom_range(0, 3) != 0);
            dp_db_i    = 16'($urandom);
        end
    end

    function automatic rec_t pop_rec();
        rec_t r;
        r = '{-1, '0, '0, '0};
        if (exp_q.size() > 0) r = exp_q.pop_front();
        return r;
    endfunction

    task automatic wait_result(output bit got);
        got = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (result_valid_o) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort_i = 1'b1;
        @(posedge clk); #1 abort_i = 1'b0;
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [PINC_W-1:0] d);
        @(posedge clk); #1;
        cfg_wr_en_i = 1'b1;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        @(posedge clk); #1;
        cfg_wr_en_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({dp_en_o, dp_flush_o, result_valid_o, busy_o} !== 4'b0 ||
            dp_pinc_o !== '0 || result_o !== '0 || result_ch_o !== '0) begin
            errors++;
            $display("FAIL reset: en=%b fl=%b v=%b busy=%b pinc=%0d res=%0d ch=%0d, want all 0",
                dp_en_o, dp_flush_o, result_valid_o, busy_o, dp_pinc_o, result_o, result_ch_o);
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_single_pass();
        bit got;
        rec_t r;
        int f0;
        for (int i = 0; i < NUM_CH; i++) write_cfg(2'(i), PINC_W'(100 * (i + 1)));
        rand_en = 1;
        continuous_i = 1'b0;
        result_ready_i = 1'b1;
        exp_q.delete();
        f0 = flush_cnt;
        pulse_start();
        for (int i = 0; i < NUM_CH; i++) begin
            wait_result(got);
            r = pop_rec();
            checks++;
            if (!got || {result_ch_o, result_o, dp_pinc_o} !== {4'(r.ch), r.avg, r.pinc}
                || result_ch_o !== 4'(i) || dp_pinc_o !== PINC_W'(100 * (i + 1))) begin
                errors++;
                $display("FAIL single_pass[%0d]: got v=%b ch=%0d res=%0d pinc=%0d, want ch=%0d res=%0d pinc=%0d",
                    i, got, result_ch_o, result_o, dp_pinc_o, i, r.avg, 100 * (i + 1));
            end
`ifdef SCAN_PEAK_HOLD_EN
            checks++;
            if (peak_o !== r.peak) begin
                errors++;
                $display("FAIL single_pass_peak[%0d]: got %0d want %0d", i, peak_o, r.peak);
            end
`endif
        end
        for (int k = 0; k < 20 && busy_o; k++) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || dp_en_o !== 1'b0 || dp_pinc_o !== PINC_W'(400)
            || flush_cnt - f0 != NUM_CH) begin
            errors++;
            $display("FAIL single_pass_end: busy=%b en=%b pinc=%0d flushes=%0d, want 0 0 400 %0d",
                busy_o, dp_en_o, dp_pinc_o, flush_cnt - f0, NUM_CH);
        end
    endtask

    task automatic test_averaging();
        bit got;
        rec_t r;
        rand_en = 0;
        exp_q.delete();
        feed_q.delete();
        repeat (SETTLE) feed_q.push_back(16'hFFFF);
        for (int i = 1; i <= NAVG; i++) feed_q.push_back(16'(10 * i));
        pulse_start();
        wait_result(got);
        r = pop_rec();
        checks++;
        if (!got || result_o !== 16'd45 || result_o !== r.avg || result_ch_o !== 4'd0) begin
            errors++;
            $display("FAIL averaging: got v=%b res=%0d ch=%0d, want res=45 ch=0", got, result_o, result_ch_o);
        end
`ifdef SCAN_PEAK_HOLD_EN
        checks++;
        if (peak_o !== 16'd80) begin
            errors++;
            $display("FAIL averaging_peak: got %0d want 80", peak_o);
        end
`endif
        pulse_abort();
        feed_q.delete();
    endtask

    task automatic test_backpressure();
        bit got;
        rec_t r;
        logic [15:0] hold_res;
        logic [3:0] hold_ch;
        rand_en = 1;
        result_ready_i = 1'b0;
        exp_q.delete();
        pulse_start();
        wait_result(got);
        r = pop_rec();
        hold_res = result_o;
        hold_ch = result_ch_o;
        checks++;
        if (!got || result_o !== r.avg || result_ch_o !== 4'(r.ch)) begin
            errors++;
            $display("FAIL backpressure_result: got res=%0d ch=%0d want res=%0d ch=%0d",
                result_o, result_ch_o, r.avg, r.ch);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if (result_o !== hold_res || result_ch_o !== hold_ch || dp_en_o !== 1'b0
                || dp_flush_o !== 1'b0 || result_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: res=%0d ch=%0d en=%b fl=%b v=%b want res=%0d ch=%0d en=0 fl=0 v=1",
                    k, result_o, result_ch_o, dp_en_o, dp_flush_o, result_valid_o, hold_res, hold_ch);
            end
        end
        @(posedge clk); #1 result_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (result_valid_o !== 1'b1 || dp_flush_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accept: v=%b fl=%b want v=1 fl=0", result_valid_o, dp_flush_o);
        end
        @(negedge clk);
        checks++;
        if (result_valid_o !== 1'b0 || dp_flush_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_advance: v=%b fl=%b want v=0 fl=1", result_valid_o, dp_flush_o);
        end
        pulse_abort();
    endtask

    task automatic test_continuous();
        bit got, hit;
        rec_t r;
        int seen;
        rand_en = 1;
        continuous_i = 1'b1;
        result_ready_i = 1'b1;
        exp_q.delete();
        pulse_start();
        for (int i = 0; i <= NUM_CH; i++) begin
            wait_result(got);
            r = pop_rec();
            checks++;
            if (!got || {result_ch_o, result_o, dp_pinc_o} !== {4'(r.ch), r.avg, r.pinc}
                || result_ch_o !== 4'(i % NUM_CH)) begin
                errors++;
                $display("FAIL continuous[%0d]: got ch=%0d res=%0d pinc=%0d, want ch=%0d res=%0d pinc=%0d",
                    i, result_ch_o, result_o, dp_pinc_o, i % NUM_CH, r.avg, r.pinc);
            end
        end
        checks++;
        if (dp_pinc_o !== PINC_W'(100)) begin
            errors++;
            $display("FAIL continuous_wrap_pinc: got %0d want 100", dp_pinc_o);
        end
        hit = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (win_open && win_cnt > SETTLE && win_cnt <= SETTLE + 5) begin
                hit = 1;
                break;
            end
        end
        pulse_abort();
        checks++;
        if (!hit || busy_o !== 1'b0 || dp_en_o !== 1'b0 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_accum: reached=%b busy=%b en=%b v=%b want 1 0 0 0",
                hit, busy_o, dp_en_o, result_valid_o);
        end
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (result_valid_o || busy_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: active cycles=%0d want 0", seen);
        end
        continuous_i = 1'b0;
    endtask

    task automatic test_cfg_write();
        bit got, hit;
        rec_t r;
        rand_en = 1;
        exp_q.delete();
        pulse_start();
        wait_result(got);
        r = pop_rec();
        hit = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (win_open && win_ch == 1 && win_cnt >= SETTLE && win_cnt <= SETTLE + 3) begin
                hit = 1;
                break;
            end
        end
        write_cfg(2'd1, PINC_W'(999));
        for (int i = 1; i < NUM_CH; i++) begin
            wait_result(got);
            r = pop_rec();
            checks++;
            if (!hit || !got || {result_ch_o, result_o, dp_pinc_o} !== {4'(r.ch), r.avg, r.pinc}
                || (i == 1 && dp_pinc_o !== PINC_W'(200))) begin
                errors++;
                $display("FAIL cfg_live[%0d]: got ch=%0d res=%0d pinc=%0d, want ch=%0d res=%0d pinc=%0d",
                    i, result_ch_o, result_o, dp_pinc_o, r.ch, r.avg, r.pinc);
            end
        end
        for (int k = 0; k < 20 && busy_o; k++) @(negedge clk);
        exp_q.delete();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            wait_result(got);
            r = pop_rec();
        end
        checks++;
        if (!got || result_ch_o !== 4'd1 || dp_pinc_o !== PINC_W'(999) || dp_pinc_o !== r.pinc
            || result_o !== r.avg) begin
            errors++;
            $display("FAIL cfg_next_visit: got ch=%0d pinc=%0d res=%0d, want ch=1 pinc=999 res=%0d",
                result_ch_o, dp_pinc_o, result_o, r.avg);
        end
        pulse_abort();
    endtask

    task automatic test_async_reset();
        bit got, hit;
        rec_t r;
        int seen;
        rand_en = 1;
        exp_q.delete();
        pulse_start();
        hit = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (win_open && win_cnt >= 1 && win_cnt <= SETTLE - 4) begin
                hit = 1;
                break;
            end
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (!hit || {dp_en_o, dp_flush_o, result_valid_o, busy_o} !== 4'b0
            || dp_pinc_o !== '0 || result_o !== '0 || result_ch_o !== '0) begin
            errors++;
            $display("FAIL async_reset: en=%b fl=%b v=%b busy=%b pinc=%0d res=%0d ch=%0d, want all 0",
                dp_en_o, dp_flush_o, result_valid_o, busy_o, dp_pinc_o, result_o, result_ch_o);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy_o || dp_en_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_needs_start: active cycles=%0d want 0", seen);
        end
        exp_q.delete();
        pulse_start();
        wait_result(got);
        r = pop_rec();
        checks++;
        if (!got || dp_pinc_o !== '0 || {result_ch_o, result_o} !== {4'(r.ch), r.avg}) begin
            errors++;
            $display("FAIL reset_table_cleared: got pinc=%0d ch=%0d res=%0d, want pinc=0 ch=%0d res=%0d",
                dp_pinc_o, result_ch_o, result_o, r.ch, r.avg);
        end
        pulse_abort();
    endtask

    task automatic test_small_cfg();
        logic [PINC_W-1:0] want_pinc [3];
        logic [15:0] want;
        bit armed;
        int nres;
        want_pinc[0] = PINC_W'(11);
        want_pinc[1] = PINC_W'(22);
        want_pinc[2] = PINC_W'(33);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            s_wr = 1'b1;
            s_addr = 2'(i);
            s_data = (i < 3) ? want_pinc[i] : PINC_W'(777);
        end
        @(posedge clk); #1 s_wr = 1'b0;
        s_valid = 1'b1;
        s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        armed = 0;
        nres = 0;
        want = '0;
        for (int cyc = 0; cyc < 200 && nres < 3; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            s_db = 16'($urandom);
            if (armed) begin
                want = s_db;
                armed = 0;
            end
            @(negedge clk);
            if (s_flush) armed = 1;
            if (s_rvalid) begin
                checks++;
                if (s_result !== want || s_rch !== 4'(nres) || s_pinc !== want_pinc[nres]) begin
                    errors++;
                    $display("FAIL small[%0d]: got res=%0d ch=%0d pinc=%0d, want res=%0d ch=%0d pinc=%0d",
                        nres, s_result, s_rch, s_pinc, want, nres, want_pinc[nres]);
                end
                nres++;
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (nres != 3 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL small_end: results=%0d busy=%b want 3 0", nres, s_busy);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pass();
        test_averaging();
        test_backpressure();
        test_continuous();
        test_cfg_write();
        test_async_reset();
        test_small_cfg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
